// File: rtl/uart_rx_ctrl.sv
// ---------------------------------------------------------------------------
// uart_rx_ctrl
//
// 8N1 UART receiver with a small receive FIFO behind a bus_simple slave
// register window. The serial line is synchronized, deframed by a small
// FSM that samples each bit near its midpoint, and completed bytes are
// queued for the CPU.
//
// Ports
//   clk        system clock
//   rst_n      synchronous active-low reset
//   req_valid  bus request strobe (one cycle per access)
//   req_write  1 = write, 0 = read
//   req_addr   byte address, only [3:0] decoded (0x0 RXDATA, 0x4 STATUS, 0x8 CTRL)
//   req_wdata  write data
//   req_wstrb  byte strobes, writes need req_wstrb[0]
//   rdata      combinational read data, 0 when not reading
//   baud_div   clocks per bit (values below 2 act as 2)
//   uart_rx    asynchronous serial input, idles high
//   rx_irq     registered interrupt: FIFO not empty and CTRL.ie
//
// Register map
//   0x0 RXDATA  RO  {24'h0, head}; a read of a non-empty FIFO pops it
//   0x4 STATUS      [0] rx_avail [1] full [2] frame_err (W1C) [3] overrun (W1C)
//                   [4] rx_busy
//   0x8 CTRL    RW  [0] rx_en (reset 1) [1] ie [2] flush (write-1, reads 0)
//
// FSM states
//   state     | meaning
//   ST_IDLE   | waiting for a 1->0 edge on rx_s (re-armed once rx_s seen high)
//   ST_START  | timing to the start-bit midpoint, rejecting false starts
//   ST_DATA   | sampling 8 data bits LSB first, one per bit period
//   ST_STOP   | sampling the stop bit; push byte or flag a framing error
// ---------------------------------------------------------------------------
module uart_rx_ctrl #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic [31:0] rdata,
    input  logic [15:0] baud_div,
    input  logic        uart_rx,
    output logic        rx_irq
);

    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    localparam logic [3:0] OFF_RXDATA = 4'h0;
    localparam logic [3:0] OFF_STATUS = 4'h4;
    localparam logic [3:0] OFF_CTRL   = 4'h8;

    // ------------------------------------------------------------------
    // Input synchronizer (resets to the idle-high line level)
    // ------------------------------------------------------------------
    logic rx_meta;
    logic rx_s;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= uart_rx;
            rx_s    <= rx_meta;
        end
    end

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic [3:0] offset;
    logic       bus_rd;
    logic       bus_wr;
    logic       wr_status;
    logic       wr_ctrl;
    logic       flush;

    assign offset    = req_addr[3:0];
    assign bus_rd    = req_valid && !req_write;
    assign bus_wr    = req_valid && req_write && req_wstrb[0];
    assign wr_status = bus_wr && (offset == OFF_STATUS);
    assign wr_ctrl   = bus_wr && (offset == OFF_CTRL);
    assign flush     = wr_ctrl && req_wdata[2];

    logic unused_bus_bits;
    assign unused_bus_bits = ^{req_addr[31:4], req_wdata[31:4], req_wstrb[3:1]};

    // ------------------------------------------------------------------
    // Control register
    // ------------------------------------------------------------------
    logic rx_en;
    logic ie;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_en <= 1'b1;
            ie    <= 1'b0;
        end else if (wr_ctrl) begin
            rx_en <= req_wdata[0];
            ie    <= req_wdata[1];
        end
    end

    // ------------------------------------------------------------------
    // Effective bit timing: baud_div clamped to at least 2
    // ------------------------------------------------------------------
    logic [15:0] bd_eff;
    logic [15:0] bd_half_m1;
    logic [15:0] bd_m1;

    assign bd_eff     = (baud_div < 16'd2) ? 16'd2 : baud_div;
    assign bd_half_m1 = {1'b0, bd_eff[15:1]} - 16'd1;
    assign bd_m1      = bd_eff - 16'd1;

    // ------------------------------------------------------------------
    // Receive FSM
    // ------------------------------------------------------------------
    logic [1:0]  state;
    logic [15:0] bit_timer;
    logic [2:0]  bit_idx;
    logic [7:0]  shreg;
    logic        armed;
    logic        timer_tc;
    logic        stop_sample;
    logic        push_req;
    logic        frame_set;

    assign timer_tc    = (bit_timer == 16'd0);
    assign stop_sample = rx_en && (state == ST_STOP) && timer_tc;
    assign push_req    = stop_sample && rx_s;
    assign frame_set   = stop_sample && !rx_s;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            bit_timer <= 16'd0;
            bit_idx   <= 3'd0;
            shreg     <= 8'h00;
            armed     <= 1'b0;
        end else if (!rx_en) begin
            // Disabling drops any partial frame; the FIFO is untouched.
            state <= ST_IDLE;
            armed <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (armed && !rx_s) begin
                        state     <= ST_START;
                        bit_timer <= bd_half_m1;
                        armed     <= 1'b0;
                    end else if (rx_s) begin
                        armed <= 1'b1;
                    end
                end
                ST_START: begin
                    if (timer_tc) begin
                        if (!rx_s) begin
                            state     <= ST_DATA;
                            bit_timer <= bd_m1;
                            bit_idx   <= 3'd0;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        bit_timer <= bit_timer - 16'd1;
                    end
                end
                ST_DATA: begin
                    if (timer_tc) begin
                        shreg[bit_idx] <= rx_s;
                        bit_timer      <= bd_m1;
                        if (bit_idx == 3'd7) begin
                            state <= ST_STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        bit_timer <= bit_timer - 16'd1;
                    end
                end
                ST_STOP: begin
                    // armed is already 0, so IDLE waits for the line to
                    // read high before accepting the next start edge.
                    if (timer_tc) begin
                        state <= ST_IDLE;
                    end else begin
                        bit_timer <= bit_timer - 16'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Receive FIFO: extra pointer bit distinguishes full from empty
    // ------------------------------------------------------------------
    logic [7:0]  fifo_mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        empty;
    logic        full;
    logic        pop;
    logic        do_push;
    logic        overrun_set;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // A read of an empty FIFO is not a pop, so push+pop while empty is push only.
    assign pop         = bus_rd && (offset == OFF_RXDATA) && !empty;
    // Flush wins over a same-edge push; a simultaneous pop frees a slot when full.
    assign do_push     = push_req && !flush && (!full || pop);
    assign overrun_set = push_req && !flush && full && !pop;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Storage needs no reset: it is only visible when the FIFO is non-empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            fifo_mem[wr_ptr[AW-1:0]] <= shreg;
        end
    end

    // ------------------------------------------------------------------
    // Sticky status flags: a set event beats a same-edge clear
    // ------------------------------------------------------------------
    logic frame_err;
    logic overrun;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= (frame_err && !(wr_status && req_wdata[2])) || frame_set;
            overrun   <= (overrun && !(wr_status && req_wdata[3])) || overrun_set;
        end
    end

    // ------------------------------------------------------------------
    // Interrupt
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_irq <= 1'b0;
        end else begin
            rx_irq <= !empty && ie;
        end
    end

    // ------------------------------------------------------------------
    // Read mux
    // ------------------------------------------------------------------
    logic rx_busy;
    assign rx_busy = (state != ST_IDLE);

    always_comb begin
        rdata = 32'h0;
        if (bus_rd) begin
            case (offset)
                OFF_RXDATA: begin
                    if (!empty) begin
                        rdata = {24'h0, fifo_mem[rd_ptr[AW-1:0]]};
                    end
                end
                OFF_STATUS: rdata = {27'h0, rx_busy, overrun, frame_err, full, !empty};
                OFF_CTRL:   rdata = {30'h0, ie, rx_en};
                default:    rdata = 32'h0;
            endcase
        end
    end

endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

8N1 UART receiver with a small receive FIFO and a bus_simple slave register window. It sits directly downstream of the `uart_rx` pin and is the receive-side companion of `uart_ctrl`, which handles TX. It samples the serial line at each bit midpoint, deframes bytes, queues them, and exposes them to the CPU through RXDATA/STATUS/CTRL registers.

## Interface
- `FIFO_DEPTH`, default 4. Receive FIFO entries; must be a power of 2, ≥2.
- `clk`  in  1  system clock (100 MHz in sim).
- `rst_n`  in  1  reset; synchronous, active-low.
- `req_valid`  in  1  bus_simple request strobe, one cycle per access.
- `req_write`  in  1  1 = write, 0 = read.
- `req_addr`  in  32  byte address; only `[3:0]` is decoded (0x0, 0x4, 0x8).
- `req_wdata`  in  32  write data.
- `req_wstrb`  in  4  byte strobes; a write takes effect only if `req_wstrb[0]` = 1.
- `rdata`  out  32  combinational read data.
- `baud_div`  in  16  clocks per bit; shared from `uart_ctrl` CTRL. Values <2 are treated as 2.
- `uart_rx`  in  1  asynchronous serial input; idles high.
- `rx_irq`  out  1  registered interrupt: FIFO not empty AND CTRL.ie.

## Operation
- **Registers** (offset = `req_addr[3:0]`; unmapped offsets read 0 and ignore writes):
  - 0x0 RXDATA (RO): `{24'h0, head}`. A read when the FIFO is non-empty pops it at the sampling clock edge. A read when empty returns 0 and does not pop.
  - 0x4 STATUS: bit0 `rx_avail` (not empty), bit1 `full`, bit2 `frame_err` (sticky), bit3 `overrun` (sticky), bit4 `rx_busy` (FSM not IDLE). Writing 1 to bit2 or bit3 clears that flag. Other bits are RO.
  - 0x8 CTRL (RW): bit0 `rx_en` (reset 1), bit1 `ie` (reset 0), bit2 `flush`. `flush` is write-1 self-clearing and empties the FIFO. It reads back 0.
- `rdata` = 0 whenever `req_valid` = 0 or `req_write` = 1.
- **Input sync:** 2-flop synchronizer on `uart_rx`, reset value 1. All FSM logic uses the synced value `rx_s`.
- **FSM:** IDLE, START, DATA, STOP. A 16-bit bit-timer and a 3-bit bit index.
  - IDLE: on `rx_s` 1→0 with `rx_en`=1 → START, load timer with `bd/2 - 1` (bd = effective baud_div).
  - START: at timer 0, sample `rx_s`. If 0 → DATA, timer = bd-1, index = 0. If 1 → IDLE (false start, no flag).
  - DATA: at timer 0, shift `rx_s` into `shreg[index]` (LSB first) and reload timer = bd-1. After index 7 → STOP.
  - STOP: at timer 0, sample `rx_s`. If 1 → push `shreg` into the FIFO. If 0 → set `frame_err` and discard the byte. Either way → IDLE. IDLE re-arms only after seeing `rx_s` = 1.
- `rx_en` cleared mid-frame: FSM returns to IDLE on the next edge, the partial byte is dropped, and FIFO contents are kept.
- `baud_div` changes mid-frame take effect at the next timer reload.

## Timing
- **Reset:** all outputs and state go to 0, except `rx_en` = 1 and sync flops = 1. FIFO is empty, flags are clear, FSM is IDLE, `rx_irq` = 0, `rdata` = 0.
- **Latency:** a line edge reaches `rx_s` after 2 clocks. The byte is visible in RXDATA and STATUS.rx_avail one clock after the STOP sample edge. `rx_irq` rises on the following edge.
- **FIFO:** read/write pointers are `log2(FIFO_DEPTH)+1` bits and wrap naturally; `full` and `empty` come from the MSB comparison.
  - Push while full with no pop: byte dropped, `overrun` set.
  - Push and pop on the same edge while full: both happen, no overrun.
  - Push and pop on the same edge while empty: push only (the pop is invalid). The read returns 0.
- Flush and push on the same edge: flush wins and the FIFO ends empty.
- Clear-write and set event on the same edge for a sticky flag: set wins.
- Pop occurs exactly once per read: `req_valid` is high for one clock edge per access.

## Test plan
- **T1 reset/CTRL:** after reset, read CTRL → 0x1 and STATUS → 0x0. Write CTRL = 0x3, read back → 0x3.
- **T2 single byte:** `baud_div` = 8; bench drives 8N1 0xA5 on `uart_rx`. STATUS.rx_avail = 1, `rx_irq` = 1. Read RXDATA → 0x000000A5. Then STATUS → 0x0 and `rx_irq` falls.
- **T3 burst/overrun:** send 0x01..0x05 back-to-back without reading. STATUS shows `full` = 1 and `overrun` = 1. Reads return 0x01..0x04, then a further read returns 0 with no pop. Write STATUS = 0x8 → `overrun` clears.
- **T4 frame error:** send 0x3C with the stop bit driven 0. `frame_err` = 1, FIFO stays empty. A following correct 0x3C is received as 0x3C.
- **T5 false start:** drive `uart_rx` low for 2 clocks (less than bd/2), then high. No byte, no flags, FSM back in IDLE. A subsequent 0x55 is received correctly.
- **T6 flush/reset mid-frame:** assert `rst_n` = 0 for 2 clocks halfway through a 0xFF frame. All outputs return to reset values and the partial byte is not pushed. Write CTRL.flush with 2 bytes queued → STATUS.rx_avail = 0.
